// File: rtl/button_conditioner_if.sv
// Raw push-button levels in, conditioned single-cycle command pulses out.
interface button_conditioner_if;
  logic BtnL;
  logic BtnR;
  logic BtnC;
  logic BtnU;
  logic Left;
  logic Right;
  logic Select;
  logic Start;

  modport master (
    output BtnL, BtnR, BtnC, BtnU,
    input  Left, Right, Select, Start
  );

  modport slave (
    input  BtnL, BtnR, BtnC, BtnU,
    output Left, Right, Select, Start
  );
endinterface

// File: rtl/button_conditioner.sv
// Four independent button channels: 2-flop synchronizer, debounce, and a
// press/hold/release FSM emitting one-cycle pulses with optional auto-repeat.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned REPEAT_DELAY    = 32'd50000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd20000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0011
) (
  input  logic                Clk,
  input  logic                Reset,
  button_conditioner_if.slave btn
);

  localparam int unsigned NCH     = 32'd4;
  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CW      = (MAX_CYC > 32'd2) ? $clog2(MAX_CYC) : 32'd1;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CW-1:0] RPD_LAST = CW'(REPEAT_DELAY - 32'd1);
  localparam logic [CW-1:0] RPP_LAST = CW'(REPEAT_PERIOD - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  typedef enum logic [2:0] {
    ST_LOCK        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_ARM_PRESS   = 3'd2,
    ST_PULSE       = 3'd3,
    ST_HELD        = 3'd4,
    ST_RPT_PULSE   = 3'd5,
    ST_RPT_WAIT    = 3'd6,
    ST_ARM_RELEASE = 3'd7
  } state_t;

  logic [NCH-1:0] raw_s;
  logic [NCH-1:0] sync1_d;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_d;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] pulse_d;
  logic [NCH-1:0] pulse_q;
  state_t         state_d [NCH];
  state_t         state_q [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [CW-1:0]  cnt_q   [NCH];

  assign raw_s      = {btn.BtnU, btn.BtnC, btn.BtnR, btn.BtnL};
  assign btn.Left   = pulse_q[0];
  assign btn.Right  = pulse_q[1];
  assign btn.Select = pulse_q[2];
  assign btn.Start  = pulse_q[3];

  // Synchronizer chain inputs.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
  end

  // Next state and counter per channel; the FSM only ever looks at sync2_q.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOCK: begin
          if (sync2_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            state_d[i] = ST_ARM_PRESS;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_ARM_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_PULSE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PULSE: begin
          state_d[i] = ST_HELD;
          cnt_d[i]   = '0;
        end
        ST_HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_ARM_RELEASE;
            cnt_d[i]   = '0;
          end else if (REPEAT_MASK[i]) begin
            if (cnt_q[i] == RPD_LAST) begin
              state_d[i] = ST_RPT_PULSE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i];
          end
        end
        ST_RPT_PULSE: begin
          state_d[i] = ST_RPT_WAIT;
          cnt_d[i]   = '0;
        end
        ST_RPT_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_ARM_RELEASE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == RPP_LAST) begin
            state_d[i] = ST_RPT_PULSE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_ARM_RELEASE: begin
          // A bounce back high returns to HELD and restarts the repeat delay.
          if (sync2_q[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_LOCK;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the pulse flop mirrors the pulse states.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pulse_d[i] = (state_d[i] == ST_PULSE) || (state_d[i] == ST_RPT_PULSE);
    end
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_LOCK;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model feeding per-channel
// expected-pulse queues, a negedge monitor, and directed plus random stimulus.
module tb_button_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam logic [3:0] MASK = 4'b0011;

  logic Clk;
  logic Reset;
  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .btn(bus)
  );

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int exp_q [4][$];
  int npulse [4];
  int last_pulse [4];
  logic [3:0] out_s;

  // Model state: 0 = locked after reset, 1 = released, 2 = held.
  int mode [4];
  int zrun [4];
  int orun [4];
  int hcnt [4];
  int tgt  [4];
  bit skip [4];
  bit p1   [4];
  bit p2   [4];

  assign out_s = {bus.Start, bus.Select, bus.Right, bus.Left};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: a pulse needs D+1 consecutive high samples while released,
  // release needs D+1 consecutive lows while held, lock needs D lows.
  initial begin
    logic [3:0] raw;
    bit s;
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        for (int c = 0; c < 4; c++) begin
          mode[c] = 0; zrun[c] = 0; orun[c] = 0; hcnt[c] = 0; tgt[c] = RD;
          skip[c] = 1'b0; p1[c] = 1'b0; p2[c] = 1'b0;
          exp_q[c].delete();
        end
      end else begin
        raw = {bus.BtnU, bus.BtnC, bus.BtnR, bus.BtnL};
        for (int c = 0; c < 4; c++) begin
          s = p2[c];
          p2[c] = p1[c];
          p1[c] = raw[c];
          if (mode[c] == 0) begin
            zrun[c] = s ? 0 : zrun[c] + 1;
            if (zrun[c] == D) begin mode[c] = 1; orun[c] = 0; end
          end else if (mode[c] == 1) begin
            orun[c] = s ? orun[c] + 1 : 0;
            if (orun[c] == D + 1) begin
              exp_q[c].push_back(cyc + 1);
              mode[c] = 2; skip[c] = 1'b1; zrun[c] = 0; hcnt[c] = 0; tgt[c] = RD;
            end
          end else if (skip[c]) begin
            skip[c] = 1'b0;
          end else if (!s) begin
            zrun[c]++;
            if (zrun[c] == D + 1) begin mode[c] = 1; orun[c] = 0; end
          end else if (zrun[c] > 0) begin
            zrun[c] = 0; hcnt[c] = 0; tgt[c] = RD;
          end else if (MASK[c]) begin
            hcnt[c]++;
            if (hcnt[c] == tgt[c]) begin
              exp_q[c].push_back(cyc + 1);
              skip[c] = 1'b1; hcnt[c] = 0; tgt[c] = RP;
            end
          end
        end
      end
    end
  end

  // Monitor: every observed pulse must match the head of its channel queue.
  initial begin
    for (int c = 0; c < 4; c++) begin npulse[c] = 0; last_pulse[c] = -1; end
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        for (int c = 0; c < 4; c++) begin
          if (out_s[c]) begin
            npulse[c]++;
            last_pulse[c] = cyc;
            if (exp_q[c].size() == 0) check($sformatf("unexpected_pulse_ch%0d", c), int'(out_s[c]), 0);
            else check($sformatf("pulse_cycle_ch%0d", c), cyc, exp_q[c].pop_front());
          end else if (exp_q[c].size() != 0 && exp_q[c][0] < cyc) begin
            check($sformatf("missing_pulse_ch%0d_at_%0d", c, exp_q[c].pop_front()), int'(out_s[c]), 1);
          end
        end
      end
    end
  end

  task automatic set_btn(input logic [3:0] v);
    bus.BtnL = v[0];
    bus.BtnR = v[1];
    bus.BtnC = v[2];
    bus.BtnU = v[3];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    int e0;
    int base;
    bit found;
    logic [3:0] lvl;
    int len [4];

    Reset = 1'b1;
    set_btn(4'b0000);
    idle(3);
    check("reset_outputs", int'(out_s), 0);
    Reset = 1'b0;
    idle(10);

    // Clean Left press: pulse exactly in the cycle after edge E0+6.
    set_btn(4'b0001);
    e0 = cyc + 1;
    while (cyc < e0 + 9) begin
      @(negedge Clk);
      check("left_latency", int'(bus.Left), int'(cyc == e0 + 6));
    end
    set_btn(4'b0000);
    idle(20);

    // Bouncy Select press then bouncy release.
    base = npulse[2];
    for (int k = 0; k < 4; k++) begin
      set_btn((k % 2 == 0) ? 4'b0100 : 4'b0000);
      idle(2);
    end
    set_btn(4'b0100);
    idle(20);
    check("select_bounce_press", npulse[2] - base, 1);
    base = npulse[2];
    for (int k = 0; k < 5; k++) begin
      set_btn((k % 2 == 0) ? 4'b0000 : 4'b0100);
      idle(2);
    end
    set_btn(4'b0000);
    idle(20);
    check("select_bounce_release", npulse[2] - base, 0);

    // Auto-repeat on Right; none on Start.
    base = npulse[1];
    set_btn(4'b0010);
    idle(40);
    set_btn(4'b0000);
    idle(20);
    check("right_repeat_count", npulse[1] - base, 6);
    base = npulse[3];
    set_btn(4'b1000);
    idle(40);
    set_btn(4'b0000);
    idle(20);
    check("start_no_repeat", npulse[3] - base, 1);

    // Start held through reset must be released before it can fire.
    set_btn(4'b1000);
    Reset = 1'b1;
    idle(3);
    base = npulse[3];
    Reset = 1'b0;
    idle(30);
    check("start_held_through_reset", npulse[3] - base, 0);
    set_btn(4'b0000);
    idle(8);
    set_btn(4'b1000);
    idle(20);
    set_btn(4'b0000);
    idle(20);
    check("start_after_release", npulse[3] - base, 1);

    // Simultaneous Left and Right.
    set_btn(4'b0011);
    e0 = cyc + 1;
    idle(12);
    set_btn(4'b0000);
    idle(20);
    check("simul_left_cycle", last_pulse[0], e0 + 6);
    check("simul_right_cycle", last_pulse[1], e0 + 6);

    // Reset during the pulse cycle kills it, and the held button stays silent.
    base = npulse[0];
    set_btn(4'b0001);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge Clk);
      #1;
      if (exp_q[0].size() != 0) found = 1'b1;
    end
    check("mid_reset_pulse_reached", int'(found), 1);
    check("left_before_reset", int'(bus.Left), 1);
    Reset = 1'b1;
    #1;
    check("left_during_reset", int'(bus.Left), 0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(30);
    check("no_pulse_after_mid_reset", npulse[0] - base, 0);
    set_btn(4'b0000);
    idle(20);

    // Random levels with short bounces and long holds on all channels.
    lvl = 4'b0000;
    for (int c = 0; c < 4; c++) len[c] = int'($urandom_range(1, 10));
    repeat (4000) begin
      for (int c = 0; c < 4; c++) begin
        if (len[c] == 0) begin
          lvl[c] = ~lvl[c];
          len[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
        end
        len[c]--;
      end
      set_btn(lvl);
      @(negedge Clk);
    end
    set_btn(4'b0000);
    idle(60);
    for (int c = 0; c < 4; c++) check($sformatf("queue_drain_ch%0d", c), exp_q[c].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the Connect Four game FSM.
- Converts four raw, bouncy, asynchronous push-button levels into clean single-cycle pulses for `Left`, `Right`, `Select` and `Start`.
- Each channel has a 2-flop synchronizer, a debounce counter and a small press/hold/release state machine.
- Optional auto-repeat lets a held Left/Right button sweep the selected column.
- Outputs connect directly to the game FSM's `Left`/`Right`/`Select`/`Start` inputs on the same `Clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles an input must be stable, high or low, before it is accepted (5 ms at 100 MHz). Minimum 2.
- `REPEAT_DELAY`, default 50000000: cycles a channel must be held after its first pulse before auto-repeat starts. Minimum 2.
- `REPEAT_PERIOD`, default 20000000: cycles between auto-repeat pulses. Minimum 2.
- `REPEAT_MASK`, default 4'b0011: per-channel auto-repeat enable. Bit order: bit0 Left, bit1 Right, bit2 Select, bit3 Start.
- `Clk  input  1`: system clock.
- `Reset  input  1`: asynchronous, active-high.
- `BtnL  input  1`: raw Left button, asynchronous.
- `BtnR  input  1`: raw Right button, asynchronous.
- `BtnC  input  1`: raw Select button, asynchronous.
- `BtnU  input  1`: raw Start button, asynchronous.
- `Left  output  1`: one-cycle pulse per accepted Left press or repeat.
- `Right  output  1`: one-cycle pulse per accepted Right press or repeat.
- `Select  output  1`: one-cycle pulse per accepted Select press.
- `Start  output  1`: one-cycle pulse per accepted Start press.

## Operation
- Four identical, fully independent channels. No cross-channel suppression: simultaneous Left+Right both pulse, and the consumer arbitrates.
- Synchronizer: `s1 <= raw; s2 <= s1`. The FSM sees only `s2`.
- Shared counter width: `$clog2` of the largest of the three cycle parameters.
- Per-channel states and transitions:
  - LOCK (reset state): if `s2`=1, clear counter. Else counter++; when counter == DEBOUNCE_CYCLES-1, go to IDLE. This forces a button held through reset to be released before it can fire.
  - IDLE: counter=0. If `s2`=1, go to ARM_PRESS.
  - ARM_PRESS: if `s2`=0, go to IDLE (a bounce, no pulse). Else counter++; when counter == DEBOUNCE_CYCLES-1, go to PULSE.
  - PULSE: output=1 for this single cycle, then go to HELD with counter=0.
  - HELD: if `s2`=0, go to ARM_RELEASE with counter=0.
    - Else, if the channel's REPEAT_MASK bit is set: counter++; when counter == REPEAT_DELAY-1, go to RPT_PULSE.
    - If the mask bit is clear, stay in HELD indefinitely.
  - RPT_PULSE: output=1 for one cycle, then go to RPT_WAIT with counter=0.
  - RPT_WAIT: if `s2`=0, go to ARM_RELEASE with counter=0. Else counter++; when counter == REPEAT_PERIOD-1, go to RPT_PULSE.
  - ARM_RELEASE: if `s2`=1, go to HELD with counter=0 (a release bounce, no pulse, repeat timer restarts). Else counter++; when counter == DEBOUNCE_CYCLES-1, go to IDLE.
- Output = (state==PULSE) | (state==RPT_PULSE), taken from a registered state, so it is glitch-free.

## Timing
- Reset values:
  - All outputs 0.
  - Synchronizer flops 0.
  - All channels in LOCK with counter 0.
- Press latency: if the first rising `Clk` edge that samples raw=1 is E0, and the input stays stable, the output pulse is high in the cycle following edge E0+DEBOUNCE_CYCLES+2.
- Every pulse is exactly 1 cycle wide. Pulses on one channel are never back-to-back.
- First repeat pulse: REPEAT_DELAY+1 cycles after the initial pulse. Subsequent repeats: every REPEAT_PERIOD+1 cycles.
- Minimum re-press interval: release (DEBOUNCE_CYCLES stable low) plus press (DEBOUNCE_CYCLES stable high).
- A stable-low glitch shorter than DEBOUNCE_CYCLES while held does not produce a new pulse.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronously). A pulse in flight is lost, never stretched.

## Test plan
- Params 4/10/5. Hold BtnL low 10 cycles after reset, then assert it cleanly at edge E0 -> `Left` is high for exactly the cycle after edge E0+6 and for no other cycle until repeats begin.
- Bounce: toggle BtnC 1,0,1,0 every 2 cycles, then hold it high 20 cycles -> exactly one `Select` pulse, occurring 6 edges after the final rising sample. Release with bounces -> no pulse.
- Auto-repeat: hold BtnR 40 cycles -> `Right` pulses at t, t+11, t+17, t+23, t+29, ... Hold BtnU 40 cycles -> exactly one `Start` pulse (mask bit clear).
- Reset-held: BtnU=1 while Reset deasserts, held for 30 cycles -> no `Start` pulse. Release for ≥4 cycles and press again -> one pulse.
- Simultaneous: BtnL and BtnR asserted on the same edge -> `Left` and `Right` pulse in the same cycle.
- Mid-operation reset: assert Reset during the PULSE cycle -> output drops to 0 within that cycle, and no further pulse follows while the button stays held.
